// File: rtl/ifu_prefetch_queue.sv
// Instruction-fetch front end: streams sequential PCs over AXI AR/R into a DEPTH-entry
// prefetch FIFO and hands {pc, inst} to decode; a redirect flushes and squashes in-flight reads.
module ifu_prefetch_queue #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] axi_AR_ADDR,
    output logic              axi_AR_VALID,
    input  logic              axi_AR_READY,
    input  logic [DATA_W-1:0] axi_R_DATA,
    input  logic              axi_R_VALID,
    output logic              axi_R_READY
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              drop_q;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [ADDR_W-1:0] redirect_pc_al;
    logic [INST_W-1:0] beat_inst;
    logic              r_fire;
    logic              push;
    logic              pop;
    logic              slot_free;
    logic              unused_redirect_lsb;

    assign redirect_pc_al      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign beat_inst = fetch_pc_q[2] ? axi_R_DATA[2*INST_W-1:INST_W] : axi_R_DATA[INST_W-1:0];

    // A squashed beat is still consumed (handshake completes) but never written.
    assign r_fire    = (state_q == StData) && axi_R_VALID;
    assign push      = r_fire && !drop_q && !redirect_valid;
    assign out_valid = (count_q != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign slot_free = count_q < CNT_W'(DEPTH);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_inst  = inst_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
                inst_mem_q[wr_ptr_q] <= beat_inst;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // One read outstanding at most; a slot is reserved at the IDLE decision so data
    // can never arrive at a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            drop_q       <= 1'b0;
            axi_AR_VALID <= 1'b0;
            axi_AR_ADDR  <= '0;
            axi_R_READY  <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc_al;
            end else if (r_fire && !drop_q) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
            end

            case (state_q)
                StIdle: begin
                    if (redirect_valid || slot_free) begin
                        state_q      <= StAddr;
                        axi_AR_VALID <= 1'b1;
                        axi_AR_ADDR  <= redirect_valid ? redirect_pc_al : fetch_pc_q;
                    end
                end
                StAddr: begin
                    if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (axi_AR_READY) begin
                        state_q      <= StData;
                        axi_AR_VALID <= 1'b0;
                        axi_R_READY  <= 1'b1;
                    end
                end
                StData: begin
                    if (axi_R_VALID) begin
                        state_q     <= StIdle;
                        axi_R_READY <= 1'b0;
                        drop_q      <= 1'b0;
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    axi_AR_VALID <= 1'b0;
                    axi_R_READY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
